// File: rtl/exe_branch_resolve.sv
// EXE-stage branch/jump resolution: one stage register, redirect on mispredict,
// a 2-bit-counter BHT read combinationally by IF, and saturating perf counters.
module exe_branch_resolve #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic                  pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] pred_addr_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  lookup_taken_o,
    output logic                  valid_o,
    output logic                  jump_enable_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  taken_o,
    output logic                  link_we_o,
    output logic [ADDR_WIDTH-1:0] link_addr_o,
    output logic                  misalign_o,
    output logic [CNT_WIDTH-1:0]  branch_cnt_o,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] inst_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] op1_reg;
    logic [DATA_WIDTH-1:0] op2_reg;
    logic                  pred_taken_reg;
    logic [ADDR_WIDTH-1:0] pred_addr_reg;
    logic [CNT_WIDTH-1:0]  branch_cnt_reg;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_reg;
    logic [1:0]            bht_mem [BHT_ENTRIES];

    logic                  capture;
    assign capture = valid_i & ~stall_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg      <= 1'b0;
            inst_reg       <= '0;
            pc_reg         <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            pred_taken_reg <= 1'b0;
            pred_addr_reg  <= '0;
        end else begin
            valid_reg <= capture;
            if (capture) begin
                inst_reg       <= inst_i;
                pc_reg         <= inst_addr_i;
                op1_reg        <= op1_i;
                op2_reg        <= op2_i;
                pred_taken_reg <= pred_taken_i;
                pred_addr_reg  <= pred_addr_i;
            end
        end
    end

    // Decode of the registered instruction
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  br_taken;
    logic                  br_legal;
    logic [ADDR_WIDTH-1:0] imm_b;
    logic [ADDR_WIDTH-1:0] imm_j;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [ADDR_WIDTH-1:0] jalr_target;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
    logic                  mispredict;
    logic                  misalign;
    logic                  out_valid;
    logic                  bht_we;

    assign opcode    = inst_reg[6:0];
    assign funct3    = inst_reg[14:12];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);

    assign imm_b = {{(ADDR_WIDTH-13){inst_reg[31]}}, inst_reg[31], inst_reg[7],
                    inst_reg[30:25], inst_reg[11:8], 1'b0};
    assign imm_j = {{(ADDR_WIDTH-21){inst_reg[31]}}, inst_reg[31], inst_reg[19:12],
                    inst_reg[20], inst_reg[30:21], 1'b0};
    assign imm_i = {{(DATA_WIDTH-12){inst_reg[31]}}, inst_reg[31:20]};

    assign jalr_sum    = op1_reg + imm_i;
    assign jalr_target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    assign pc_plus4    = pc_reg + ADDR_WIDTH'(4);

    always_comb begin
        br_taken = 1'b0;
        br_legal = 1'b1;
        case (funct3)
            3'b000:  br_taken = (op1_reg == op2_reg);
            3'b001:  br_taken = (op1_reg != op2_reg);
            3'b100:  br_taken = ($signed(op1_reg) <  $signed(op2_reg));
            3'b101:  br_taken = ($signed(op1_reg) >= $signed(op2_reg));
            3'b110:  br_taken = (op1_reg <  op2_reg);
            3'b111:  br_taken = (op1_reg >= op2_reg);
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        target = pc_reg + imm_b;
        taken  = br_taken;
        if (is_jal) begin
            target = pc_reg + imm_j;
            taken  = 1'b1;
        end else if (is_jalr) begin
            target = jalr_target;
            taken  = 1'b1;
        end
    end

    // Reset gates the stage combinationally so an in-flight redirect never escapes
    assign out_valid  = valid_reg & (is_branch | is_jal | is_jalr) & ~rst_i;
    assign mispredict = (taken != pred_taken_reg) | (taken & (target != pred_addr_reg));
    assign misalign   = taken & (target[1:0] != 2'b00);
    assign bht_we     = out_valid & is_branch & br_legal;

    assign valid_o       = out_valid;
    assign jump_enable_o = out_valid & mispredict & ~misalign;
    assign jump_addr_o   = out_valid ? (taken ? target : pc_plus4) : '0;
    assign taken_o       = out_valid & taken;
    assign link_we_o     = out_valid & (is_jal | is_jalr);
    assign link_addr_o   = (out_valid & (is_jal | is_jalr)) ? pc_plus4 : '0;
    assign misalign_o    = out_valid & misalign;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else if (out_valid) begin
            if (branch_cnt_reg != '1)
                branch_cnt_reg <= branch_cnt_reg + CNT_WIDTH'(1);
            if (mispredict && (mispredict_cnt_reg != '1))
                mispredict_cnt_reg <= mispredict_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign branch_cnt_o     = branch_cnt_reg;
    assign mispredict_cnt_o = mispredict_cnt_reg;

    // BHT: trained at the edge ending the output cycle, so same-cycle lookups see the old value
    logic [IDX-1:0] train_idx;
    logic [IDX-1:0] lookup_idx;
    assign train_idx  = pc_reg[IDX+1:2];
    assign lookup_idx = lookup_addr_i[IDX+1:2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_mem[i] <= 2'b01;
        end else if (bht_we) begin
            if (br_taken) begin
                if (bht_mem[train_idx] != 2'b11)
                    bht_mem[train_idx] <= bht_mem[train_idx] + 2'b01;
            end else begin
                if (bht_mem[train_idx] != 2'b00)
                    bht_mem[train_idx] <= bht_mem[train_idx] - 2'b01;
            end
        end
    end

    assign lookup_taken_o = bht_mem[lookup_idx][1];

    logic unused_bits;
    assign unused_bits = ^{lookup_addr_i[ADDR_WIDTH-1:IDX+2], lookup_addr_i[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_exe_branch_resolve.sv
// Scoreboard bench for exe_branch_resolve: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid_o is presented.
module tb_exe_branch_resolve;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        pred_taken_i = 1'b0;
    logic [31:0] pred_addr_i = '0;
    logic [31:0] lookup_addr_i = '0;
    logic        lookup_taken_o;
    logic        valid_o;
    logic        jump_enable_o;
    logic [31:0] jump_addr_o;
    logic        taken_o;
    logic        link_we_o;
    logic [31:0] link_addr_o;
    logic        misalign_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    exe_branch_resolve dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .op1_i(op1_i), .op2_i(op2_i), .pred_taken_i(pred_taken_i),
        .pred_addr_i(pred_addr_i), .lookup_addr_i(lookup_addr_i),
        .lookup_taken_o(lookup_taken_o), .valid_o(valid_o),
        .jump_enable_o(jump_enable_o), .jump_addr_o(jump_addr_o),
        .taken_o(taken_o), .link_we_o(link_we_o), .link_addr_o(link_addr_o),
        .misalign_o(misalign_o), .branch_cnt_o(branch_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        taken;
        logic        jen;
        logic [31:0] jaddr;
        logic        lwe;
        logic [31:0] laddr;
        logic        mal;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic look(input string name, input logic [31:0] addr, input logic exp);
        lookup_addr_i = addr;
        #1;
        chk(name, 64'(lookup_taken_o), 64'(exp));
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_branch_cnt"}, 64'(branch_cnt_o), 64'(exp_br));
        chk({name, "_mispredict_cnt"}, 64'(mispredict_cnt_o), 64'(exp_mis));
    endtask

    // Issue one instruction (called at posedge+1), wait out its output cycle and the training edge.
    task automatic send(input string name, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] op1, input logic [31:0] op2,
                        input logic pt, input logic [31:0] pa,
                        input logic e_cf, input logic e_taken, input logic e_jen,
                        input logic [31:0] e_jaddr, input logic e_lwe,
                        input logic [31:0] e_laddr, input logic e_mal, input logic e_mis,
                        input int rdw_exp);
        exp_t e;
        valid_i = 1'b1; inst_i = inst; inst_addr_i = pc; op1_i = op1; op2_i = op2;
        pred_taken_i = pt; pred_addr_i = pa;
        if (e_cf) begin
            e.name = name; e.taken = e_taken; e.jen = e_jen; e.jaddr = e_jaddr;
            e.lwe = e_lwe; e.laddr = e_laddr; e.mal = e_mal;
            sb_q.push_back(e);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        if (!e_cf) chk({name, "_no_valid"}, 64'(valid_o), 64'd0);
        if (rdw_exp >= 0) begin
            lookup_addr_i = pc;
            #1;
            chk({name, "_rdw_lookup"}, 64'(lookup_taken_o), 64'(rdw_exp[0]));
        end
        @(posedge clk_i); #1;
        if (e_cf) begin
            exp_br++;
            if (e_mis) exp_mis++;
        end
        chk_counts(name);
    endtask

    // A captured-but-blocked instruction must leave no trace at all.
    task automatic blocked(input string name, input logic fl, input logic st);
        valid_i = 1'b1; flush_i = fl; stall_i = st;
        inst_i = enc_b(3'b000, 13'd16); inst_addr_i = 32'h118;
        op1_i = 32'd7; op2_i = 32'd7; pred_taken_i = 1'b0; pred_addr_i = 32'h0;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        chk({name, "_no_valid"}, 64'(valid_o), 64'd0);
        chk({name, "_no_redirect"}, 64'(jump_enable_o), 64'd0);
        @(posedge clk_i); #1;
        chk_counts(name);
        look({name, "_bht"}, 32'h118, 1'b0);
    endtask

    // Monitor: compare every presented result against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (valid_o) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got valid_o=1 jaddr=%h expected no output", jump_addr_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if ({taken_o, jump_enable_o, jump_addr_o, link_we_o, link_addr_o, misalign_o} !==
                        {e.taken, e.jen, e.jaddr, e.lwe, e.laddr, e.mal}) begin
                        errors++;
                        $display("FAIL %s: got taken=%b jen=%b jaddr=%h lwe=%b laddr=%h mal=%b expected taken=%b jen=%b jaddr=%h lwe=%b laddr=%h mal=%b",
                                 e.name, taken_o, jump_enable_o, jump_addr_o, link_we_o, link_addr_o, misalign_o,
                                 e.taken, e.jen, e.jaddr, e.lwe, e.laddr, e.mal);
                    end else begin
                        $display("txn %s: taken=%b jen=%b jaddr=%h lwe=%b laddr=%h mal=%b",
                                 e.name, taken_o, jump_enable_o, jump_addr_o, link_we_o, link_addr_o, misalign_o);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk_counts("reset");
        look("reset_lookup_100", 32'h100, 1'b0);
        look("reset_lookup_1fc", 32'h1FC, 1'b0);

        //    name        inst                        pc            op1           op2    pt    pa        cf    tk    jen   jaddr         lwe   laddr         mal   mis   rdw
        send("beq_t",   enc_b(3'b000, 13'd16),      32'h100,      32'd5,        32'd5, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h110,      1'b0, 32'h0,        1'b0, 1'b1, 0);
        look("beq_bht", 32'h100, 1'b1);
        send("blt_t",   enc_b(3'b100, 13'd8),       32'h204,      32'hFFFFFFFF, 32'd1, 1'b1, 32'h20C,  1'b1, 1'b1, 1'b0, 32'h20C,      1'b0, 32'h0,        1'b0, 1'b0, -1);
        look("blt_bht", 32'h204, 1'b1);
        send("bltu_nt", enc_b(3'b110, 13'd8),       32'h208,      32'hFFFFFFFF, 32'd1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h20C,      1'b0, 32'h0,        1'b0, 1'b0, -1);
        look("bltu_bht", 32'h208, 1'b0);
        send("jalr_i0", enc_jalr(12'd0),            32'h300,      32'h203,      32'd0, 1'b1, 32'h202,  1'b1, 1'b1, 1'b0, 32'h202,      1'b1, 32'h304,      1'b1, 1'b0, -1);
        send("jalr_i2", enc_jalr(12'd2),            32'h300,      32'h203,      32'd0, 1'b1, 32'h202,  1'b1, 1'b1, 1'b1, 32'h204,      1'b1, 32'h304,      1'b0, 1'b1, -1);
        send("jal_neg", enc_jal(21'h1FFFF8),        32'h400,      32'd0,        32'd0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h3F8,      1'b1, 32'h404,      1'b0, 1'b1, -1);
        send("beq_mal", enc_b(3'b000, 13'd6),       32'h10C,      32'd9,        32'd9, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h112,      1'b0, 32'h0,        1'b1, 1'b1, -1);
        send("jal_wrap", enc_jal(21'd8),            32'hFFFFFFFC, 32'd0,        32'd0, 1'b1, 32'h4,    1'b1, 1'b1, 1'b0, 32'h4,        1'b1, 32'h0,        1'b0, 1'b0, -1);
        for (int k = 0; k < 4; k++)
            send("bne_t", enc_b(3'b001, 13'd16),    32'h110,      32'd1,        32'd2, 1'b1, 32'h120,  1'b1, 1'b1, 1'b0, 32'h120,      1'b0, 32'h0,        1'b0, 1'b0, -1);
        look("bne_sat", 32'h110, 1'b1);
        send("bne_nt1", enc_b(3'b001, 13'd16),      32'h110,      32'd3,        32'd3, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h114,      1'b0, 32'h0,        1'b0, 1'b0, -1);
        look("bne_dec1", 32'h110, 1'b1);
        send("bne_nt2", enc_b(3'b001, 13'd16),      32'h110,      32'd3,        32'd3, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h114,      1'b0, 32'h0,        1'b0, 1'b0, -1);
        look("bne_dec2", 32'h110, 1'b0);
        send("f3_010",  enc_b(3'b010, 13'd16),      32'h114,      32'd3,        32'd3, 1'b1, 32'h0,    1'b1, 1'b0, 1'b1, 32'h118,      1'b0, 32'h0,        1'b0, 1'b1, -1);
        look("f3_010_bht", 32'h114, 1'b0);
        send("add_ncf", 32'h002081B3,               32'h120,      32'd1,        32'd1, 1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, -1);

        blocked("flush", 1'b1, 1'b0);
        blocked("stall", 1'b0, 1'b1);

        // Reset while a mispredicting BEQ sits in the stage register
        valid_i = 1'b1; inst_i = enc_b(3'b000, 13'd16); inst_addr_i = 32'h11C;
        op1_i = 32'd4; op2_i = 32'd4; pred_taken_i = 1'b0; pred_addr_i = 32'h0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("midrst_no_valid", 64'(valid_o), 64'd0);
        chk("midrst_no_redirect", 64'(jump_enable_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_br = 0;
        exp_mis = 0;
        chk_counts("midrst");
        look("midrst_bht_100", 32'h100, 1'b0);
        look("midrst_bht_11c", 32'h11C, 1'b0);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
